// File: rtl/key_pulse_gen_if.sv
// ----------------------------------------------------------------------------
// key_pulse_gen_if
//   Signal bundle between the raw stopwatch push-buttons and key_pulse_gen.
//
//   key_ps_n    : raw pause/start button, active-low, asynchronous
//   key_rst_n   : raw clear button, active-low, asynchronous
//   key_ps_en   : one-cycle pause/start enable pulse
//   key_rst_en  : one-cycle clear enable pulse
//   key_ps_held : level, pause/start key is in a debounced-pressed state
//
//   master : button / counter side (drives keys, receives pulses)
//   slave  : key_pulse_gen side
// ----------------------------------------------------------------------------
interface key_pulse_gen_if;
    logic key_ps_n;
    logic key_rst_n;
    logic key_ps_en;
    logic key_rst_en;
    logic key_ps_held;

    modport master (
        output key_ps_n,
        output key_rst_n,
        input  key_ps_en,
        input  key_rst_en,
        input  key_ps_held
    );

    modport slave (
        input  key_ps_n,
        input  key_rst_n,
        output key_ps_en,
        output key_rst_en,
        output key_ps_held
    );
endinterface

// File: rtl/key_pulse_gen.sv
// ----------------------------------------------------------------------------
// key_pulse_gen
//   Turns the two bouncy active-low stopwatch buttons into clean one-cycle
//   enable pulses. Each key: 2-flop synchronizer, then an independent
//   IDLE / PRESS_DB / HELD / RELEASE_DB debounce FSM with its own counter.
//
//   Ports:
//     clk   : system clock (1 kHz), rising edge
//     rst_n : asynchronous active-low reset
//     bus   : key_pulse_gen_if.slave (key_ps_n, key_rst_n in;
//             key_ps_en, key_rst_en, key_ps_held out)
//
//   Optional feature macro: KEY_LONGPRESS_EN
//     Defined   : holding pause/start for LONG_CNT cycles also issues one
//                 key_rst_en pulse per press.
//     Undefined : no long-press behaviour.
// ----------------------------------------------------------------------------
module key_pulse_gen #(
    parameter int DEBOUNCE_CNT = 20,
    parameter int LONG_CNT     = 2000,
    parameter int CNT_W        = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    key_pulse_gen_if.slave  bus
);

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_PRESS_DB   = 2'd1;
    localparam logic [1:0] S_HELD       = 2'd2;
    localparam logic [1:0] S_RELEASE_DB = 2'd3;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] DB_PRE  = CNT_W'(DEBOUNCE_CNT - 2);
    // One saturation bound serves both debounce and long-press counting;
    // debounce counts never get near it.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LONG_CNT);

    // Index 0 = pause/start key, index 1 = clear key.
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0][1:0]       r_state;
    logic [1:0][CNT_W-1:0] r_cnt;
    logic                  r_ps_en;
    logic                  r_rst_en;

    logic [1:0][1:0]       w_state_nxt;
    logic [1:0][CNT_W-1:0] w_cnt_nxt;
    logic [1:0][CNT_W-1:0] w_cnt_inc;
    logic [1:0]            w_accept;
    logic                  w_long_fire;

    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            w_state_nxt[k] = r_state[k];
            w_cnt_nxt[k]   = r_cnt[k];
            w_cnt_inc[k]   = (r_cnt[k] < CNT_SAT) ? r_cnt[k] + 1'b1 : r_cnt[k];
            // Look ahead through s1 (the next s2 value) so the registered
            // pulse appears in the last PRESS_DB cycle, exactly when the
            // PRESS_DB -> HELD transition is guaranteed on the next edge.
            w_accept[k]    = (r_state[k] == S_PRESS_DB) && !r_sync2[k] &&
                             !r_sync1[k] && (r_cnt[k] == DB_PRE);
            case (r_state[k])
                S_IDLE: begin
                    if (!r_sync2[k]) begin
                        w_state_nxt[k] = S_PRESS_DB;
                        w_cnt_nxt[k]   = '0;
                    end
                end
                S_PRESS_DB: begin
                    if (r_sync2[k]) begin
                        w_state_nxt[k] = S_IDLE;
                    end else if (r_cnt[k] == DB_LAST) begin
                        w_state_nxt[k] = S_HELD;
                        w_cnt_nxt[k]   = '0;
                    end else begin
                        w_cnt_nxt[k]   = w_cnt_inc[k];
                    end
                end
                S_HELD: begin
                    if (r_sync2[k]) begin
                        w_state_nxt[k] = S_RELEASE_DB;
                        w_cnt_nxt[k]   = '0;
                    end
                end
                S_RELEASE_DB: begin
                    if (!r_sync2[k]) begin
                        w_state_nxt[k] = S_HELD;
                        w_cnt_nxt[k]   = '0;
                    end else if (r_cnt[k] == DB_LAST) begin
                        w_state_nxt[k] = S_IDLE;
                    end else begin
                        w_cnt_nxt[k]   = w_cnt_inc[k];
                    end
                end
                default: begin
                    w_state_nxt[k] = S_IDLE;
                    w_cnt_nxt[k]   = '0;
                end
            endcase
        end
`ifdef KEY_LONGPRESS_EN
        // Pause/start keeps counting held cycles for the long-press clear.
        if ((r_state[0] == S_HELD) && !r_sync2[0]) begin
            w_cnt_nxt[0] = w_cnt_inc[0];
        end
`endif
    end

`ifdef KEY_LONGPRESS_EN
    localparam logic [CNT_W-1:0] LONG_PRE = CNT_W'(LONG_CNT - 2);

    logic r_long_armed;

    // Fires on the edge where the held count reaches LONG_CNT-1.
    assign w_long_fire = r_long_armed && (r_state[0] == S_HELD) &&
                         !r_sync2[0] && (r_cnt[0] == LONG_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_armed <= 1'b1;
        end else if (r_state[0] == S_IDLE) begin
            r_long_armed <= 1'b1;
        end else if (w_long_fire) begin
            r_long_armed <= 1'b0;
        end
    end
`else
    assign w_long_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_state  <= {S_IDLE, S_IDLE};
            r_cnt    <= '0;
            r_ps_en  <= 1'b0;
            r_rst_en <= 1'b0;
        end else begin
            r_sync1  <= {bus.key_rst_n, bus.key_ps_n};
            r_sync2  <= r_sync1;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ps_en  <= w_accept[0];
            r_rst_en <= w_accept[1] | w_long_fire;
        end
    end

    assign bus.key_ps_en   = r_ps_en;
    assign bus.key_rst_en  = r_rst_en;
    assign bus.key_ps_held = (r_state[0] == S_HELD) || (r_state[0] == S_RELEASE_DB);

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;
    localparam int DB   = 20;
    localparam int LONG = 2000;
`ifdef KEY_LONGPRESS_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_pulse_gen_if u_if ();

    key_pulse_gen #(
        .DEBOUNCE_CNT (DB),
        .LONG_CNT     (LONG),
        .CNT_W        (12)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    // Behavioural model: per key, a run-length of raw samples that disagree
    // with the accepted level; DB+1 such samples flip the accepted level.
    bit m_pressed [2];
    int m_run     [2];
    bit m_acc_d1  [2];
    bit m_held_d1, m_held_d2;
    bit m_fire_d1, m_fire_d2;
    bit exp_ps_en, exp_rst_en, exp_held;
`ifdef KEY_LONGPRESS_EN
    int m_lowcnt = 0;
    bit m_armed  = 1'b1;
`endif

    // Observed pulse statistics for the directed checks.
    int ps_cnt = 0, rst_cnt = 0, both_cnt = 0;
    int first_ps = 0, first_rst = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pressed[k] = 1'b0;
            m_run[k]     = 0;
            m_acc_d1[k]  = 1'b0;
        end
        m_held_d1 = 1'b0; m_held_d2 = 1'b0;
        m_fire_d1 = 1'b0; m_fire_d2 = 1'b0;
        exp_ps_en = 1'b0; exp_rst_en = 1'b0; exp_held = 1'b0;
`ifdef KEY_LONGPRESS_EN
        m_lowcnt = 0;
        m_armed  = 1'b1;
`endif
    endtask

    // Raw sample at edge n: press pulse visible after edge n+1, held level
    // and long-press pulse visible after edge n+2.
    task automatic model_step(input logic raw_ps, input logic raw_rst);
        logic raw [2];
        bit   acc [2];
        bit   fire;
        raw[0] = raw_ps;
        raw[1] = raw_rst;
        fire   = 1'b0;
        exp_ps_en  = m_acc_d1[0];
        exp_rst_en = m_acc_d1[1] | m_fire_d2;
        exp_held   = m_held_d2;
        for (int k = 0; k < 2; k++) begin
            acc[k] = 1'b0;
            if (!m_pressed[k]) begin
                if (raw[k] == 1'b0) begin
                    m_run[k]++;
                    if (m_run[k] == DB + 1) begin
                        m_pressed[k] = 1'b1;
                        m_run[k]     = 0;
                        acc[k]       = 1'b1;
`ifdef KEY_LONGPRESS_EN
                        if (k == 0) m_lowcnt = 0;
`endif
                    end
                end else begin
                    m_run[k] = 0;
                end
            end else if (raw[k] == 1'b1) begin
                m_run[k]++;
                if (m_run[k] == DB + 1) begin
                    m_pressed[k] = 1'b0;
                    m_run[k]     = 0;
                end
            end else begin
`ifdef KEY_LONGPRESS_EN
                if (k == 0) begin
                    if (m_run[0] != 0) m_lowcnt = 0;
                    else if (m_lowcnt < LONG) m_lowcnt++;
                    if (m_armed && m_lowcnt == LONG - 1) begin
                        fire    = 1'b1;
                        m_armed = 1'b0;
                    end
                end
`endif
                m_run[k] = 0;
            end
        end
`ifdef KEY_LONGPRESS_EN
        if (!m_pressed[0]) m_armed = 1'b1;
`endif
        m_fire_d2 = m_fire_d1; m_fire_d1 = fire;
        m_held_d2 = m_held_d1; m_held_d1 = m_pressed[0];
        m_acc_d1  = acc;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_no++;
        end
    end

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(u_if.key_ps_n, u_if.key_rst_n);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("key_ps_en",   u_if.key_ps_en,   exp_ps_en);
            chk("key_rst_en",  u_if.key_rst_en,  exp_rst_en);
            chk("key_ps_held", u_if.key_ps_held, exp_held);
            if (u_if.key_ps_en === 1'b1) begin
                ps_cnt++;
                if (first_ps == 0) first_ps = edge_no;
            end
            if (u_if.key_rst_en === 1'b1) begin
                rst_cnt++;
                if (first_rst == 0) first_rst = edge_no;
            end
            if (u_if.key_ps_en === 1'b1 && u_if.key_rst_en === 1'b1) both_cnt++;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        ps_cnt = 0; rst_cnt = 0; both_cnt = 0;
        first_ps = 0; first_rst = 0;
    endtask

    int t0;

    initial begin
        u_if.key_ps_n  = 1'b1;
        u_if.key_rst_n = 1'b1;
        rst_n = 1'b0;
        wait_cycles(2);
        chk("reset_ps_en",   u_if.key_ps_en,   0);
        chk("reset_rst_en",  u_if.key_rst_en,  0);
        chk("reset_ps_held", u_if.key_ps_held, 0);

        // Key already held while reset releases counts as a new press.
        u_if.key_ps_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        t0 = edge_no;
        clear_obs();
        wait_cycles(40);
        chk("rsthold_latency", first_ps - t0, 22);
        chk("rsthold_count", ps_cnt, 1);
        u_if.key_ps_n = 1'b1;
        wait_cycles(40);

        // Clean press.
        clear_obs();
        u_if.key_ps_n = 1'b0;
        t0 = edge_no;
        wait_cycles(50);
        u_if.key_ps_n = 1'b1;
        wait_cycles(10);
        chk("clean_held_in_release", u_if.key_ps_held, 1);
        wait_cycles(30);
        chk("clean_held_after", u_if.key_ps_held, 0);
        chk("clean_latency", first_ps - t0, 22);
        chk("clean_count", ps_cnt, 1);
        chk("clean_no_rst", rst_cnt, 0);

        // Bounce on press, then bounce on release.
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            u_if.key_ps_n = ((i / 3) % 2) != 0;
            wait_cycles(1);
        end
        u_if.key_ps_n = 1'b0;
        t0 = edge_no;
        wait_cycles(40);
        chk("bounce_latency", first_ps - t0, 22);
        for (int i = 0; i < 30; i++) begin
            u_if.key_ps_n = ((i / 5) % 2) == 0;
            wait_cycles(1);
        end
        u_if.key_ps_n = 1'b1;
        wait_cycles(40);
        chk("bounce_count", ps_cnt, 1);

        // Short glitch on clear key.
        clear_obs();
        u_if.key_rst_n = 1'b0;
        wait_cycles(20);
        u_if.key_rst_n = 1'b1;
        wait_cycles(30);
        chk("glitch_no_rst", rst_cnt, 0);

        // Simultaneous press.
        clear_obs();
        u_if.key_ps_n  = 1'b0;
        u_if.key_rst_n = 1'b0;
        t0 = edge_no;
        wait_cycles(100);
        u_if.key_ps_n  = 1'b1;
        u_if.key_rst_n = 1'b1;
        wait_cycles(40);
        chk("simul_both", both_cnt, 1);
        chk("simul_ps_count", ps_cnt, 1);
        chk("simul_rst_count", rst_cnt, 1);
        chk("simul_rst_latency", first_rst - t0, 22);

        // Long hold, twice (long-press clear only with the feature built in).
        for (int rep = 0; rep < 2; rep++) begin
            clear_obs();
            u_if.key_ps_n = 1'b0;
            t0 = edge_no;
            wait_cycles(rep == 0 ? 3000 : 2100);
            chk("long_ps_latency", first_ps - t0, 22);
            chk("long_ps_count", ps_cnt, 1);
            chk("long_rst_count", rst_cnt, LONG_EN);
            if (LONG_EN != 0) chk("long_rst_latency", first_rst - t0, 22 + LONG);
            u_if.key_ps_n = 1'b1;
            wait_cycles(40);
        end

        // Randomized segments with occasional mid-operation reset.
        for (int seg = 0; seg < 160; seg++) begin
            u_if.key_ps_n  = $urandom_range(0, 1);
            u_if.key_rst_n = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                wait_cycles($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            wait_cycles($urandom_range(1, 45));
        end

        u_if.key_ps_n  = 1'b1;
        u_if.key_rst_n = 1'b1;
        wait_cycles(50);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
